ws2811_stream_encoder: RTL and testbench
========================================

Name: ws2811_stream_encoder

Overview:
- Parametrised successor to the single-bit ws2811Encoder.
- Accepts bytes over a valid/ready handshake into an internal FIFO and serialises them MSB-first as a WS2811 waveform.
- Bit and reset timing are set by parameters. A per-byte last flag closes the frame with a latch (reset) low period.
- Sits between the satellite's data path and the LED output pin. Its output must be decodable by ws2811Decoder.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
- TBIT_CYC, 82, masterClk cycles per bit (≈1240 ns at 66.5 MHz).
- T1H_CYC, 40, high cycles for a 1 bit (≈600 ns).
- T0H_CYC, 17, high cycles for a 0 bit (≈250 ns).
- TRESET_CYC, 3325, low cycles for the latch (≈50 µs).
- Legality: 0 < T0H_CYC < T1H_CYC < TBIT_CYC. Illegal values abort elaboration via $error.

Ports:
- masterClk, input, 1, sole clock.
- reset, input, 1, synchronous, active-high.
- dataIn, input, 8, byte to transmit.
- dataLast, input, 1, byte is the final byte of the frame.
- dataValid, input, 1, producer has a byte.
- dataReady, output, 1, FIFO can accept a byte.
- dataOut, output, 1, WS2811 serial line.
- active, output, 1, a frame is being transmitted or latched.
- fifoLevel, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- underrun, output, 1, one-cycle pulse when the FIFO runs dry mid-frame.

Behaviour:
Reset
- Synchronous, active-high. On the first masterClk edge with reset high:
  - dataOut=0, active=0, underrun=0, fifoLevel=0, dataReady=0.
  - FIFO is flushed and the state machine goes to IDLE.
- dataReady goes to 1 on the first cycle after reset deasserts.
- A reset mid-bit or mid-latch truncates the waveform immediately. No partial latch is emitted.

Handshake and FIFO
- A byte (with its dataLast flag) is written on any edge where dataValid && dataReady.
- dataReady = !full, registered.
- A push and a pop in the same cycle leave fifoLevel unchanged.
- When full, dataReady=0 and pushes are ignored. A push while dataReady=0 is dropped; no overwrite.

State machine
- IDLE:
  - dataOut=0, active=0.
  - If the FIFO is non-empty, pop into the shift register and go to HIGH.
  - Latency: a byte pushed at edge N into an empty FIFO raises dataOut at edge N+2.
- HIGH:
  - dataOut=1 for T1H_CYC or T0H_CYC cycles, selected by the current MSB. active=1.
- LOW:
  - dataOut=0 for the remaining TBIT_CYC minus high cycles; every bit period is exactly TBIT_CYC.
  - Bits 7..1: shift left and go to HIGH.
  - After bit 0, if the byte had last=1, go to LATCH.
  - After bit 0 with last=0 and FIFO non-empty, pop the next byte in the final LOW cycle and go to HIGH. No gap between bytes.
  - After bit 0 with last=0 and FIFO empty, pulse underrun for 1 cycle and go to LATCH; the frame is closed implicitly.
- LATCH:
  - dataOut=0, active=1 for exactly TRESET_CYC cycles, then go to IDLE.
  - Pushes are accepted during LATCH. They are not transmitted before the latch completes.

Other rules
- Counters are sized $clog2(max(TBIT_CYC, TRESET_CYC))+1 bits and never wrap.
- dataLast on an otherwise-empty frame is legal: one byte followed by the latch.

Optional Feature:
- Macro: WS2811_ENC_BYTECOUNT_EN.
- When defined, add output port byteCount [15:0]:
  - Cleared on reset and on the IDLE→HIGH transition.
  - Increments when bit 0 of each byte completes.
  - Holds its value through LATCH and IDLE until the next frame starts.
  - Saturates at 16'hFFFF.
- When undefined, the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Push 0x55, 0xAA, 0x00, 0xFF (last on 0xFF) into an idle encoder.
  - Expect active=1 throughout the frame.
  - ws2811Decoder receiver recovers 55 AA 00 FF.
  - dataOut is low for exactly 3325 cycles, then active=0.
- Push a single 0x80 with last=1.
  - Expect first high pulse = 40 cycles and period = 82.
  - Expect the seven following high pulses = 17 cycles each.
  - Expect dataOut to rise exactly 2 edges after the push.
- Hold dataValid=1 with 20 bytes while the encoder transmits.
  - Expect dataReady=0 when fifoLevel=16 and no bytes lost.
  - Receiver output matches all 20 bytes in order.
  - No inter-byte gap longer than TBIT_CYC.
- Push 0x12 (last=0), then starve the FIFO.
  - Expect an underrun pulse for exactly one cycle after bit 0, followed by a 3325-cycle latch.
  - Receiver shows 0x12 and active drops.
- Assert reset for 1 cycle mid-way through the second byte of a 4-byte frame.
  - Expect dataOut=0 and fifoLevel=0 on the next edge.
  - Expect dataReady=1 one cycle after reset deasserts.
  - A following frame A5 5A is received correctly.
- With WS2811_ENC_BYTECOUNT_EN defined, send a 3-byte frame.
  - Expect byteCount=3 after the latch, held until the next frame.
  - Expect byteCount=0 when the next frame starts.

Source files
------------

// File: rtl/ws2811_stream_encoder_if.sv
// Byte-stream handshake bundle feeding the WS2811 stream encoder.
// Latency: n/a (wiring only).
// Backpressure: producer holds dataIn/dataLast/dataValid until it sees dataReady at a clock edge.
//
// Signals:
//   dataIn    [7:0] byte to transmit (MSB sent first)
//   dataLast        byte closes the current frame
//   dataValid       producer has a byte
//   dataReady       encoder FIFO can accept a byte (registered, low while full or in reset)
interface ws2811_stream_encoder_if;
  logic [7:0] dataIn;
  logic       dataLast;
  logic       dataValid;
  logic       dataReady;

  modport master (
    output dataIn,
    output dataLast,
    output dataValid,
    input  dataReady
  );

  modport slave (
    input  dataIn,
    input  dataLast,
    input  dataValid,
    output dataReady
  );
endinterface

// File: rtl/ws2811_stream_encoder.sv
// WS2811 stream encoder: buffers bytes in a FIFO and serialises them MSB-first as WS2811 pulses.
// Latency: a byte pushed at edge N into an idle, empty encoder raises dataOut at edge N+2.
// Backpressure: dataReady (registered) drops while the FIFO is full; pushes without dataReady are dropped.
//
// Ports:
//   masterClk        sole clock
//   reset            synchronous, active-high; flushes FIFO, truncates any bit or latch in flight
//   in_if (slave)    dataIn/dataLast/dataValid in, dataReady out
//   dataOut          WS2811 serial line
//   active           high from the first bit of a frame until its latch low period completes
//   fifoLevel        FIFO occupancy, $clog2(FIFO_DEPTH)+1 bits
//   underrun         one-cycle pulse when a frame runs dry without a last byte
//   byteCount[15:0]  only with WS2811_ENC_BYTECOUNT_EN defined: bytes sent in the current/last frame
//
// Optional feature macro: WS2811_ENC_BYTECOUNT_EN

// Small generic synchronous FIFO with registered ready and occupancy.
// Latency: written data is visible on rd_dat_o one cycle after the push edge.
// Backpressure: wr_rdy_o is registered !full; a simultaneous push and pop keeps level_o unchanged.
module ws2811_enc_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_vld_i,
  output logic                   wr_rdy_o,
  input  logic [WIDTH-1:0]       wr_dat_i,
  output logic                   rd_vld_o,
  input  logic                   rd_rdy_i,
  output logic [WIDTH-1:0]       rd_dat_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             rdy_q;
  logic             push;
  logic             pop;

  assign push = wr_vld_i && rdy_q;
  assign pop  = rd_rdy_i && (level_q != '0);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      // Ready is derived from the next occupancy so it is exact on the following edge.
      rdy_q   <= (level_d != LW'(DEPTH));
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_dat_i;
  end

  assign wr_rdy_o = rdy_q;
  assign rd_vld_o = (level_q != '0);
  assign rd_dat_o = mem_q[rptr_q];
  assign level_o  = level_q;
endmodule

module ws2811_stream_encoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int TBIT_CYC   = 82,
  parameter int T1H_CYC    = 40,
  parameter int T0H_CYC    = 17,
  parameter int TRESET_CYC = 3325
) (
  input  logic                        masterClk,
  input  logic                        reset,
  ws2811_stream_encoder_if.slave      in_if,
  output logic                        dataOut,
  output logic                        active,
  output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
  output logic                        underrun
`ifdef WS2811_ENC_BYTECOUNT_EN
  ,
  output logic [15:0]                 byteCount
`endif
);
  localparam int CNT_MAX = (TBIT_CYC > TRESET_CYC) ? TBIT_CYC : TRESET_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  if (!((T0H_CYC > 0) && (T0H_CYC < T1H_CYC) && (T1H_CYC < TBIT_CYC))) begin : g_bad_timing
    $error("ws2811_stream_encoder: need 0 < T0H_CYC < T1H_CYC < TBIT_CYC");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ws2811_stream_encoder: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TRESET_CYC < 1) begin : g_bad_reset
    $error("ws2811_stream_encoder: TRESET_CYC must be positive");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          last_q, last_d;
  logic          dout_q;
  logic          act_q;
  logic          und_q;

  logic          pop;
  logic          rd_vld;
  logic [8:0]    rd_dat;
  logic [CW-1:0] hi_cyc;
  logic [CW-1:0] lo_end;
  logic          frame_start;
  logic          byte_done;

  ws2811_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk_i    (masterClk),
    .rst_i    (reset),
    .wr_vld_i (in_if.dataValid),
    .wr_rdy_o (in_if.dataReady),
    .wr_dat_i ({in_if.dataLast, in_if.dataIn}),
    .rd_vld_o (rd_vld),
    .rd_rdy_i (pop),
    .rd_dat_o (rd_dat),
    .level_o  (fifoLevel)
  );

  // Shift register holds the current bit in [7] for both its HIGH and LOW phases,
  // so the LOW length can be derived from the same selection as the HIGH length.
  assign hi_cyc = sh_q[7] ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign lo_end = CW'(TBIT_CYC) - hi_cyc - CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    last_d      = last_q;
    pop         = 1'b0;
    frame_start = 1'b0;
    byte_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_vld) begin
          pop         = 1'b1;
          sh_d        = rd_dat[7:0];
          last_d      = rd_dat[8];
          bit_d       = '0;
          cnt_d       = '0;
          frame_start = 1'b1;
          state_d     = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt_q == hi_cyc - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOW: begin
        if (cnt_q == lo_end) begin
          cnt_d = '0;
          if (bit_q != 3'd7) begin
            sh_d    = {sh_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            state_d = S_HIGH;
          end else begin
            byte_done = 1'b1;
            if (last_q) begin
              state_d = S_LATCH;
            end else if (rd_vld) begin
              // Back-to-back byte: load during the final LOW cycle so no gap appears.
              pop     = 1'b1;
              sh_d    = rd_dat[7:0];
              last_d  = rd_dat[8];
              bit_d   = '0;
              state_d = S_HIGH;
            end else begin
              // Starved mid-frame; last_q stays 0, which marks this latch as an underrun.
              state_d = S_LATCH;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == CW'(TRESET_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the registered state one cycle later; every pulse
  // and period keeps its length, only the whole waveform is shifted by a cycle.
  always_ff @(posedge masterClk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      dout_q  <= 1'b0;
      act_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      dout_q  <= (state_q == S_HIGH);
      act_q   <= (state_q != S_IDLE);
      und_q   <= (state_q == S_LATCH) && (cnt_q == '0) && !last_q;
    end
  end

  assign dataOut  = dout_q;
  assign active   = act_q;
  assign underrun = und_q;

`ifdef WS2811_ENC_BYTECOUNT_EN
  logic [15:0] bc_q;

  always_ff @(posedge masterClk) begin
    if (reset) begin
      bc_q <= '0;
    end else if (frame_start) begin
      bc_q <= '0;
    end else if (byte_done && (bc_q != 16'hFFFF)) begin
      bc_q <= bc_q + 16'd1;
    end
  end

  assign byteCount = bc_q;
`else
  logic unused_bc;
  assign unused_bc = frame_start ^ byte_done;
`endif
endmodule

// File: tb/tb_ws2811_stream_encoder.sv
module tb_ws2811_stream_encoder;
  localparam int TBIT   = 82;
  localparam int T1H    = 40;
  localparam int T0H    = 17;
  localparam int TRESET = 3325;

  logic       masterClk = 1'b0;
  logic       reset     = 1'b1;
  logic       dataOut;
  logic       active;
  logic [4:0] fifoLevel;
  logic       underrun;
`ifdef WS2811_ENC_BYTECOUNT_EN
  logic [15:0] byteCount;
`endif

  ws2811_stream_encoder_if dIf();

  ws2811_stream_encoder dut (
    .masterClk (masterClk),
    .reset     (reset),
    .in_if     (dIf),
    .dataOut   (dataOut),
    .active    (active),
    .fifoLevel (fifoLevel),
    .underrun  (underrun)
`ifdef WS2811_ENC_BYTECOUNT_EN
    ,
    .byteCount (byteCount)
`endif
  );

  always #5 masterClk = ~masterClk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model state: bytes expected on the line, and what a WS2811 receiver recovers.
  logic [8:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         hw_q[$];
  int         per_q[$];

  int         cyc = 0;
  logic       prev_d = 1'b0;
  int         rise_cyc = 0;
  bit         have_rise = 0;
  bit         in_frame = 0;
  bit         latching = 0;
  bit         byte_done = 0;
  bit         last_flag = 0;
  int         nbits = 0;
  logic [7:0] acc = '0;
  logic [7:0] nb;
  logic [8:0] e;
  int         width;
  bit         rose;
  bit         exp_u;
  int         und_cnt = 0;

  always @(negedge masterClk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      prev_d    = 1'b0;
      have_rise = 0;
      in_frame  = 0;
      latching  = 0;
      byte_done = 0;
      nbits     = 0;
      acc       = '0;
    end else begin
      rose  = dataOut && !prev_d;
      exp_u = 0;
      if (rose) begin
        if (in_frame && have_rise) begin
          chk("bit_period", cyc - rise_cyc, TBIT);
          per_q.push_back(cyc - rise_cyc);
        end
        chk("latch_after_last", in_frame && byte_done && last_flag, 0);
        in_frame  = 1;
        have_rise = 1;
        byte_done = 0;
        rise_cyc  = cyc;
      end
      if (!dataOut && prev_d) begin
        width = cyc - rise_cyc;
        hw_q.push_back(width);
        if (width != T1H) chk("pulse_width", width, T0H);
        nb = {acc[6:0], (width == T1H)};
        acc = nb;
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          byte_done = 1;
          rx_q.push_back(nb);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected actual=%02h required=none", nb);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", nb, e[7:0]);
            last_flag = e[8];
          end
        end
      end
      if (in_frame && have_rise && !latching && !rose && (cyc == rise_cyc + TBIT)) begin
        chk("frame_end_on_byte", nbits, 0);
        latching = 1;
        exp_u    = !last_flag;
      end
      if (underrun) und_cnt++;
      chk("underrun", underrun, exp_u);
      if (latching && (cyc == rise_cyc + TBIT + TRESET)) begin
        latching  = 0;
        in_frame  = 0;
        have_rise = 0;
      end
      chk("active", active, in_frame);
      prev_d = dataOut;
    end
  end

  task automatic push(input logic [7:0] b, input logic l);
    int guard = 0;
    @(negedge masterClk);
    dIf.dataIn    = b;
    dIf.dataLast  = l;
    dIf.dataValid = 1'b1;
    while (!dIf.dataReady && guard < 5000) begin
      @(negedge masterClk);
      guard++;
    end
    if (!dIf.dataReady) chk("push_timeout", guard, 0);
    else exp_q.push_back({l, b});
    @(posedge masterClk);
    #1 dIf.dataValid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge masterClk);
      n++;
      if (!active && !dataOut && fifoLevel == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) chk("idle_timeout", n, 0);
    chk("bytes_lost", exp_q.size(), 0);
  endtask

  task automatic stream20();
    int i = 0;
    int guard = 0;
    bit done_full = 0;
    logic [7:0] b;
    while (i < 20 && guard < 20000) begin
      @(negedge masterClk);
      guard++;
      if (i == 17 && !done_full) begin
        chk("full_level", fifoLevel, 16);
        chk("full_ready", dIf.dataReady, 0);
        done_full = 1;
      end
      b = 8'(i * 29 + 3);
      dIf.dataIn    = b;
      dIf.dataLast  = (i == 19);
      dIf.dataValid = 1'b1;
      if (dIf.dataReady) begin
        exp_q.push_back({(i == 19), b});
        i++;
      end
    end
    @(posedge masterClk);
    #1 dIf.dataValid = 1'b0;
    chk("stream_accepted", i, 20);
  endtask

  initial begin
    logic [7:0] t1 [4];
    int n;
    t1[0] = 8'h55; t1[1] = 8'hAA; t1[2] = 8'h00; t1[3] = 8'hFF;
    dIf.dataIn    = '0;
    dIf.dataLast  = 1'b0;
    dIf.dataValid = 1'b0;

    repeat (3) @(posedge masterClk);
    #1;
    chk("rst_dataOut", dataOut, 0);
    chk("rst_active", active, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", fifoLevel, 0);
    chk("rst_ready", dIf.dataReady, 0);
    reset = 1'b0;
    @(posedge masterClk);
    #1 chk("ready_after_rst", dIf.dataReady, 1);

    // Four-byte frame
    rx_q.delete();
    for (int i = 0; i < 4; i++) push(t1[i], i == 3);
    wait_idle(8000);
    chk("t1_count", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("t1_byte", rx_q[i], t1[i]);
    chk("t1_no_underrun", und_cnt, 0);

    // Single 0x80: latency and pulse shapes
    rx_q.delete(); hw_q.delete(); per_q.delete();
    push(8'h80, 1'b1);
    @(posedge masterClk);
    #1 chk("rise_n1", dataOut, 0);
    @(posedge masterClk);
    #1 chk("rise_n2", dataOut, 1);
    wait_idle(5000);
    chk("t2_pulses", hw_q.size(), 8);
    if (hw_q.size() == 8) begin
      chk("t2_first_high", hw_q[0], 40);
      for (int i = 1; i < 8; i++) chk("t2_zero_high", hw_q[i], 17);
    end
    if (per_q.size() > 0) chk("t2_period", per_q[0], 82);
    chk("t2_rx", (rx_q.size() == 1) ? rx_q[0] : 9'h1FF, 8'h80);

    // Held-valid stream of 20 bytes through a 16-deep FIFO
    rx_q.delete();
    stream20();
    wait_idle(20000);
    chk("t3_count", rx_q.size(), 20);

    // Starved frame
    rx_q.delete();
    push(8'h12, 1'b0);
    wait_idle(5000);
    chk("t4_rx", (rx_q.size() == 1) ? rx_q[0] : 9'h1FF, 8'h12);
    chk("t4_underruns", und_cnt, 1);

    // Reset in the middle of the second byte of a four-byte frame
    rx_q.delete();
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
    n = 0;
    while (rx_q.size() < 1 && n < 3000) begin @(negedge masterClk); n++; end
    chk("t5_first_byte", rx_q.size(), 1);
    repeat (300) @(negedge masterClk);
    @(posedge masterClk);
    #1 reset = 1'b1;
    @(posedge masterClk);
    #1;
    chk("t5_dataOut", dataOut, 0);
    chk("t5_level", fifoLevel, 0);
    chk("t5_active", active, 0);
    reset = 1'b0;
    @(posedge masterClk);
    #1 chk("t5_ready", dIf.dataReady, 1);
    rx_q.delete();
    push(8'hA5, 1'b0); push(8'h5A, 1'b1);
    wait_idle(6000);
    chk("t5_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("t5_b0", rx_q[0], 8'hA5);
      chk("t5_b1", rx_q[1], 8'h5A);
    end

`ifdef WS2811_ENC_BYTECOUNT_EN
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b1);
    wait_idle(7000);
    chk("bc_after_latch", byteCount, 3);
    repeat (10) @(negedge masterClk);
    chk("bc_held", byteCount, 3);
    push(8'h04, 1'b1);
    n = 0;
    while (!dataOut && n < 10) begin @(negedge masterClk); n++; end
    chk("bc_rise_seen", dataOut, 1);
    chk("bc_cleared", byteCount, 0);
    wait_idle(5000);
    chk("bc_single", byteCount, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule
